pool_out_writer: RTL

- Consumer end of the pooling controller's output stream.
- Captures each pooled value qualified by pool_done and buffers it in a small FIFO.
- Writes buffered values to the output feature-map memory through a req/gnt handshake, in row-major order starting at a base address.
- Signals frame completion once pooling_finish is seen and the FIFO has fully drained.

---
 rtl/pool_out_writer_pkg.sv | 19 +
 rtl/pool_out_writer_if.sv | 16 +
 rtl/pool_out_writer_fifo.sv | 69 ++++++
 rtl/pool_out_writer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/pool_out_writer_pkg.sv
// Shared types and helpers for the pooled-output writer.
// Holds the writer state encoding, the output-width helper and the default element width.
package pool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } wr_state_e;

  localparam int DATA_W_DEF = 16;

  // Pooled output side length for a systolic row of sys_width+1 columns.
  function automatic int out_w_f(input int sys_width);
    return (sys_width + 1) / 2;
  endfunction

endpackage

// File: rtl/pool_out_writer_if.sv
// Write port toward the output feature-map memory.
// The writer drives this through the master modport; the memory drives it through the slave modport.
interface pool_out_writer_if
  import pool_pkg::*;
#(
  parameter int addr_w = 8,
  parameter int data_w = DATA_W_DEF
);
  logic              mem_wr_req;
  logic              mem_wr_gnt;
  logic [addr_w-1:0] mem_wr_addr;
  logic [data_w-1:0] mem_wr_data;

  modport master (output mem_wr_req, output mem_wr_addr, output mem_wr_data, input mem_wr_gnt);
  modport slave  (input mem_wr_req, input mem_wr_addr, input mem_wr_data, output mem_wr_gnt);
endinterface

// File: rtl/pool_out_writer_fifo.sv
// Small synchronous FIFO with registered storage and no write-to-read bypass.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module pool_sync_fifo #(
  parameter int width = 16,
  parameter int depth = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [width-1:0]       wdata,
  output logic [width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);
  localparam int PW = $clog2(depth);
  localparam logic [PW:0] FULL_CNT = depth[PW:0];

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             wr_en_s, rd_en_s;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    rd_en_s  = pop && !empty;
    wr_en_s  = push && (!full || rd_en_s);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared on reset so the read port shows zero while idle after reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/pool_out_writer.sv
// Buffers pooled elements and writes them row-major to the output feature map from a latched base.
// Raises frame_done once the frame is finished and the buffer has drained.
module pool_out_writer
  import pool_pkg::*;
#(
  parameter int sys_width  = 27,
  parameter int data_w     = DATA_W_DEF,
  parameter int addr_w     = 8,
  parameter int fifo_depth = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [addr_w-1:0] base_addr,
  input  logic              pool_done,
  input  logic [data_w-1:0] pool_data,
  input  logic              pooling_finish,
  pool_out_writer_if.master mem,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic              count_err
);
  localparam int OUT_W    = out_w_f(sys_width);
  localparam int EXPECTED = OUT_W * OUT_W;
  localparam int IDX_W    = $clog2(EXPECTED + 1) + 1;
  localparam int CNT_W    = $clog2(fifo_depth) + 1;
  localparam logic [IDX_W-1:0] EXP_IDX = EXPECTED[IDX_W-1:0];

  wr_state_e         state_q, state_d;
  logic [addr_w-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ovf_q, ovf_d, cerr_q, cerr_d, busy_q, busy_d, done_q, done_d;
  logic              push_s, req_s, xfer_s, fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]  fifo_cnt_s;
  logic [data_w-1:0] fifo_head_s;

  pool_sync_fifo #(.width(data_w), .depth(fifo_depth)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push_s),
    .pop   (xfer_s),
    .wdata (pool_data),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_cnt_s)
  );

  assign req_s  = ((state_q == ST_COLLECT) || (state_q == ST_DRAIN)) && (fifo_cnt_s != '0);
  assign xfer_s = req_s && mem.mem_wr_gnt;

  assign mem.mem_wr_req  = req_s;
  assign mem.mem_wr_data = fifo_head_s;
  assign mem.mem_wr_addr = base_q + addr_w'(idx_q);
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overflow   = ovf_q;
  assign count_err  = cerr_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    cerr_d  = cerr_q;
    push_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_COLLECT;
          base_d  = base_addr;
          idx_d   = '0;
          ovf_d   = 1'b0;
          cerr_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        push_s = pool_done;
        if (pooling_finish) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      // An empty FIFO means no request is up, so the write index is final here.
      ST_DRAIN: begin
        if (fifo_empty_s) begin
          state_d = ST_DONE;
          cerr_d  = (idx_q != EXP_IDX);
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (push_s && fifo_full_s && !xfer_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
    if (xfer_s && (idx_q != {IDX_W{1'b1}})) begin
      idx_d = idx_q + 1'b1;
    end else begin
      idx_d = idx_d;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Writer FSM, address index and status flags.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      cerr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      cerr_q  <= cerr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule
